fetch_predict_unit: RTL and testbench
=====================================

# fetch_predict_unit

Parametrised instruction-fetch front end for the 5-stage RISC-V pipeline. It replaces the bare PC adder/mux/register and the IF/ID register with one block that adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. The BTB predicts taken branches and jumps at fetch time, so correctly predicted taken branches no longer cost a flush. It sits between instruction memory and decode, and is trained and corrected by the branch unit in EX.

## Interface
Parameters:
- PC_W, 9, PC / instruction-address width.
- INS_W, 32, instruction width.
- BTB_DEPTH, 16, number of BTB entries; must be a power of 2, with 2 ≤ BTB_DEPTH ≤ 2^(PC_W-3).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard stall: hold the PC and the IF/ID outputs.
- redirect_i  in  1  EX mispredict/flush request.
- redirect_pc  in  PC_W  corrected fetch address.
- upd_valid  in  1  BTB training strobe from EX.
- upd_pc  in  PC_W  PC of the resolved control instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  PC_W  resolved target.
- imem_addr  out  PC_W  current PC to instruction memory.
- imem_rdata  in  INS_W  instruction at imem_addr, same cycle (combinational read).
- if_pc  out  PC_W  IF/ID: PC of the fetched instruction.
- if_instr  out  INS_W  IF/ID: fetched instruction.
- if_valid  out  1  IF/ID entry is a real instruction (0 = bubble).
- if_pred_taken  out  1  IF/ID: instruction was predicted taken.
- if_pred_target  out  PC_W  IF/ID: predicted target (0 when not predicted taken).

## Operation
- **BTB indexing:** index = pc[IDX_W+1:2] with IDX_W = $clog2(BTB_DEPTH). tag = pc[PC_W-1:IDX_W+2].
- **BTB entry:** {valid, tag, target, ctr[1:0]}.
- **Lookup** (combinational, on the PC): hit = valid && tag match. Predict taken when hit && ctr[1].
- **Next-PC priority:**
  1. redirect_i: {redirect_pc[PC_W-1:2], 2'b00}.
  2. stall_i: hold the PC.
  3. Predicted taken: the entry target.
  4. Otherwise: PC+4.
- **PC arithmetic:** modulo 2^PC_W (0x1FC + 4 = 0x000 at PC_W=9). pc[1:0] is always 00.
- **IF/ID capture:**
  - redirect_i: if_valid←0, if_instr←0, if_pc←0, pred fields←0.
  - else stall_i: all if_* outputs hold.
  - else: capture PC, imem_rdata, the prediction, and if_valid←1.
- **Training on upd_valid:**
  - Hit, taken: ctr saturating +1 (max 3), target←upd_target.
  - Hit, not taken: ctr saturating −1 (min 0).
  - Miss, taken: allocate {1, tag, upd_target, 2'b10}, overwriting any alias.
  - Miss, not taken: no change.
- **Simultaneous training and lookup** on the same index: the lookup sees pre-update contents. Training is independent of stall_i and redirect_i.

## Timing
- **Reset (async, while reset=0):**
  - PC = RESET_PC.
  - if_valid = 0, if_pc = 0, if_instr = 0, if_pred_taken = 0, if_pred_target = 0.
  - All BTB valid bits = 0, all counters = 2'b01.
- **Fetch latency:** the instruction at imem_addr appears on if_* one edge later. First if_valid=1 is at the first edge after reset deasserts.
- **Redirect:** at edge N, PC←redirect_pc and if_valid←0. The redirect_pc instruction appears on if_* at edge N+1.
- **Training:** written at the edge where upd_valid=1; visible to lookups from the next cycle.
- **Reset mid-operation:** aborts immediately. The BTB is cleared, so no prediction survives reset.

## Configuration
- FETCH_BTB_EN defined: BTB storage and prediction as above.
- FETCH_BTB_EN undefined:
  - No BTB storage is synthesised.
  - Next PC is always PC+4 unless redirect or stall.
  - upd_* inputs are ignored.
  - if_pred_taken = 0 and if_pred_target = 0 permanently.
  - Other timing is unchanged.

## Structure
- Shared package fetch_pkg:
  - btb_entry_t struct.
  - Counter constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - if_id_out_t struct {pc, instr, valid, pred_taken, pred_target}, mirrored into the pipeline-buffer package for the decode stage.
- One sub-module, btb_table: the storage array with a combinational lookup port and a registered training port. It is instantiated only under FETCH_BTB_EN.

## Test plan
- **Sequential fetch:** release reset, no stall → imem_addr 0x000, 0x004, 0x008; if_pc trails by one edge with if_valid=1. From PC 0x1FC the next PC is 0x000.
- **Train and predict:** upd pc=0x010, taken, target=0x040 → on the next fetch of 0x010, if_pred_taken=1 is captured and the following imem_addr=0x040. One not-taken update (ctr 2→1) → 0x010 then fetches 0x014.
- **Aliasing:** train 0x010 taken (BTB_DEPTH=16) → a fetch of 0x050 (same index, different tag) misses and goes to 0x054.
- **Stall versus redirect:** stall_i=1 for 3 cycles → imem_addr and if_* constant. stall_i=1 and redirect_i=1 with redirect_pc=0x083 → PC=0x080 and if_valid=0 at the next edge.
- **Reset mid-run:** with 0x010 trained, pull reset low for 1 cycle → PC=0x000, if_valid=0, and 0x010 then fetches 0x014.
- **Macro off:** repeat the train-and-predict scenario without FETCH_BTB_EN → if_pred_taken stays 0 and 0x010 fetches 0x014.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: BTB entry, counter encodings and the IF/ID record
// handed to decode. Types here use the default 9-bit PC / 16-entry geometry.
package fetch_pkg;

  localparam int FETCH_PC_W  = 9;
  localparam int FETCH_INS_W = 32;
  localparam int FETCH_TAG_W = 3;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                   valid;
    logic [FETCH_TAG_W-1:0] tag;
    logic [FETCH_PC_W-1:0]  target;
    logic [1:0]             ctr;
  } btb_entry_t;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
    logic                   valid;
    logic                   pred_taken;
    logic [FETCH_PC_W-1:0]  pred_target;
  } if_id_out_t;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != CTR_ST) nxt = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_predict_unit_btb_table.sv
// Direct-mapped BTB storage: combinational lookup port, registered training port.
// Lookups during a same-cycle update observe the pre-update entry.
module btb_table
  import fetch_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lookup_pc_i,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t           tbl_q [DEPTH];
  entry_t           lk_e;
  entry_t           up_e;
  entry_t           up_d;
  logic             up_hit;
  logic             up_we;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] up_tag;
  logic [PC_W-1:0]  up_tgt_aligned;
  logic             unused_lsb;

  assign unused_lsb     = ^{lookup_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};
  assign lk_idx         = lookup_pc_i[IDX_W+1:2];
  assign lk_tag         = lookup_pc_i[PC_W-1:IDX_W+2];
  assign up_idx         = upd_pc_i[IDX_W+1:2];
  assign up_tag         = upd_pc_i[PC_W-1:IDX_W+2];
  assign up_tgt_aligned = {upd_target_i[PC_W-1:2], 2'b00};

  always_comb begin
    lk_e          = tbl_q[lk_idx];
    pred_taken_o  = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.ctr[1];
    pred_target_o = pred_taken_o ? lk_e.target : '0;
  end

  always_comb begin
    up_e   = tbl_q[up_idx];
    up_hit = up_e.valid && (up_e.tag == up_tag);
    up_we  = 1'b0;
    up_d   = up_e;
    if (upd_valid_i) begin
      if (up_hit) begin
        up_we    = 1'b1;
        up_d.ctr = ctr_train(up_e.ctr, upd_taken_i);
        if (upd_taken_i) up_d.target = up_tgt_aligned;
      end else if (upd_taken_i) begin
        // Allocation simply overwrites whatever alias occupied the slot.
        up_we = 1'b1;
        up_d  = '{valid: 1'b1, tag: up_tag, target: up_tgt_aligned, ctr: CTR_WT};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (up_we) begin
      tbl_q[up_idx] <= up_d;
    end
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// Fetch front end: PC register, next-PC selection, IF/ID register and optional
// BTB prediction (enabled with the FETCH_BTB_EN macro).
module fetch_predict_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W      = 9,
  parameter int              INS_W     = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr,
  output logic             if_valid,
  output logic             if_pred_taken,
  output logic [PC_W-1:0]  if_pred_target
);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
    logic             valid;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
  } if_id_t;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  if_id_t          if_q;
  if_id_t          if_d;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            unused_in;

`ifdef FETCH_BTB_EN
  assign unused_in = ^redirect_pc[1:0];

  btb_table #(
    .PC_W  (PC_W),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk           (clk),
    .rst_n         (reset),
    .lookup_pc_i   (pc_q),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_valid_i   (upd_valid),
    .upd_pc_i      (upd_pc),
    .upd_taken_i   (upd_taken),
    .upd_target_i  (upd_target)
  );
`else
  assign unused_in   = ^{redirect_pc[1:0], upd_valid, upd_pc, upd_taken, upd_target};
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
`endif

  always_comb begin
    pc_d = pc_q;
    if (redirect_i)      pc_d = {redirect_pc[PC_W-1:2], 2'b00};
    else if (stall_i)    pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;
    else                 pc_d = pc_q + PC_W'(4);
  end

  // Redirect squashes to a bubble; stall freezes the entry.
  always_comb begin
    if_d = if_q;
    if (redirect_i) begin
      if_d = '0;
    end else if (!stall_i) begin
      if_d.pc          = pc_q;
      if_d.instr       = imem_rdata;
      if_d.valid       = 1'b1;
      if_d.pred_taken  = pred_taken;
      if_d.pred_target = pred_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= {RESET_PC[PC_W-1:2], 2'b00};
      if_q <= '0;
    end else begin
      pc_q <= pc_d;
      if_q <= if_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_pc          = if_q.pc;
  assign if_instr       = if_q.instr;
  assign if_valid       = if_q.valid;
  assign if_pred_taken  = if_q.pred_taken;
  assign if_pred_target = if_q.pred_target;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench for fetch_predict_unit; expectations follow FETCH_BTB_EN.
module tb_fetch_predict_unit;

`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, redirect_i;
  logic [8:0]  redirect_pc;
  logic        upd_valid, upd_taken;
  logic [8:0]  upd_pc, upd_target;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [8:0]  if_pc;
  logic [31:0] if_instr;
  logic        if_valid, if_pred_taken;
  logic [8:0]  if_pred_target;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  assign imem_rdata = ins_of(imem_addr);

  fetch_predict_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_valid       (if_valid),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target)
  );

  typedef struct {
    logic       stall;
    logic       redir;
    logic [8:0] rpc;
    logic [8:0] exp_addr;
    logic [8:0] exp_pc;
    logic       exp_v;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_if(input string nm, input logic [8:0] e_addr, input logic [8:0] e_pc,
                        input logic e_v, input logic e_pt, input logic [8:0] e_ptgt);
    chk({nm, ".imem_addr"}, 32'(imem_addr), 32'(e_addr));
    chk({nm, ".if_pc"}, 32'(if_pc), 32'(e_pc));
    chk({nm, ".if_valid"}, 32'(if_valid), 32'(e_v));
    chk({nm, ".if_instr"}, if_instr, e_v ? ins_of(e_pc) : 32'h0);
    chk({nm, ".if_pred_taken"}, 32'(if_pred_taken), 32'(e_pt));
    chk({nm, ".if_pred_target"}, 32'(if_pred_target), 32'(e_ptgt));
  endtask

  task automatic idle_inputs();
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [8:0] a);
    redirect_i = 1'b1; redirect_pc = a;
    step();
    idle_inputs();
  endtask

  task automatic train(input logic [8:0] pc, input logic tk, input logic [8:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 9'h000, 9'h004, 9'h000, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 9'h000, 9'h008, 9'h004, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 9'h000, 9'h008, 9'h004, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 9'h000, 9'h008, 9'h004, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 9'h000, 9'h008, 9'h004, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 9'h1FB, 9'h1F8, 9'h000, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 9'h000, 9'h1FC, 9'h1F8, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 9'h000, 9'h000, 9'h1FC, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 9'h000, 9'h004, 9'h000, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 9'h083, 9'h080, 9'h000, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 9'h000, 9'h084, 9'h080, 1'b1};

    idle_inputs();
    reset = 1'b0;
    step();
    chk_if("reset", 9'h000, 9'h000, 1'b0, 1'b0, 9'h000);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      stall_i = tbl[i].stall; redirect_i = tbl[i].redir; redirect_pc = tbl[i].rpc;
      step();
      chk_if($sformatf("vec%0d", i), tbl[i].exp_addr, tbl[i].exp_pc, tbl[i].exp_v, 1'b0, 9'h000);
    end
    idle_inputs();

    // Train 0x010 taken -> 0x040 while redirecting to 0x008.
    train(9'h010, 1'b1, 9'h040);
    redirect_to(9'h008);
    chk_if("train.redir", 9'h008, 9'h000, 1'b0, 1'b0, 9'h000);
    step();
    step();
    chk_if("train.pre", 9'h010, 9'h00C, 1'b1, 1'b0, 9'h000);
    step();
    chk_if("train.pred", BTB_ON ? 9'h040 : 9'h014, 9'h010, 1'b1, BTB_ON, BTB_ON ? 9'h040 : 9'h000);
    step();
    chk_if("train.tgt", BTB_ON ? 9'h044 : 9'h018, BTB_ON ? 9'h040 : 9'h014, 1'b1, 1'b0, 9'h000);

    // One not-taken update weakens the counter to 01: no prediction.
    train(9'h010, 1'b0, 9'h000);
    redirect_to(9'h010);
    step();
    chk_if("weak.nt", 9'h014, 9'h010, 1'b1, 1'b0, 9'h000);

    // Re-strengthen to 10, then check aliasing entry 0x050 misses.
    train(9'h010, 1'b1, 9'h040);
    redirect_to(9'h050);
    step();
    chk_if("alias", 9'h054, 9'h050, 1'b1, 1'b0, 9'h000);
    redirect_to(9'h010);
    step();
    chk_if("retrain", BTB_ON ? 9'h040 : 9'h014, 9'h010, 1'b1, BTB_ON, BTB_ON ? 9'h040 : 9'h000);

    // Asynchronous reset mid-run clears PC, IF/ID and BTB.
    step();
    reset = 1'b0;
    #1;
    chk_if("rst.async", 9'h000, 9'h000, 1'b0, 1'b0, 9'h000);
    step();
    chk_if("rst.hold", 9'h000, 9'h000, 1'b0, 1'b0, 9'h000);
    reset = 1'b1;
    redirect_to(9'h010);
    step();
    chk_if("rst.cleared", 9'h014, 9'h010, 1'b1, 1'b0, 9'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
